clk_div_ctrl: RTL and testbench

Synchronous, programmable clock-enable divider controller that replaces ripple-style divider chains with a single-clock counter. It accepts divide-ratio requests through a valid/ready handshake and switches ratios only at a period boundary, so downstream logic never sees a truncated or glitched period. It produces a one-cycle `tick` strobe every N cycles and a divided square-wave `div_out`, both clocked by `clk`. It sits between configuration logic and any block that needs a slower rate, and is the single owner of the divided-rate resource.

---
 rtl/clk_div_ctrl_if.sv | 12 +
 rtl/clk_div_ctrl.sv | 93 +++++++++
 tb/tb_clk_div_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Ratio-request handshake between configuration logic and clk_div_ctrl.
// The master offers a divide ratio and the slave signals when it can take one.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Single-clock programmable divider: emits a tick strobe and a square wave every N cycles,
// switching to a newly requested ratio only at a period boundary.
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  clk_div_ctrl_if.slave    cfg,
  output logic             tick,
  output logic             div_out,
  output logic             active,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X = (CNT_W + 1)'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_cur_div, w_cur_nxt;
  logic [CNT_W-1:0] r_pend_div, w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_adv;
  logic [CNT_W:0]   w_half;
  logic             w_last;
  logic             w_accept;

  // Extra bit on the half-period add keeps N = 2^CNT_W-1 from wrapping to zero.
  assign w_last    = (r_cnt == r_cur_div - ONE);
  assign w_half    = ({1'b0, r_cur_div} + ONE_X) >> 1;
  assign w_cnt_adv = w_last ? '0 : r_cnt + ONE;

  assign cfg.cfg_ready = ena && (r_state != PEND);
  assign w_accept      = cfg.cfg_valid && cfg.cfg_ready;

  assign active  = (r_state != IDLE);
  assign tick    = active && w_last && ena;
  assign div_out = active && ({1'b0, r_cnt} < w_half);
  assign cur_div = r_cur_div;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur_div;
    w_pend_nxt  = r_pend_div;
    if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_accept && (cfg.cfg_div != '0)) begin
            w_cur_nxt   = cfg.cfg_div;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          w_cnt_nxt = w_cnt_adv;
          // A request taken on the tick cycle waits for the following boundary.
          if (w_accept) begin
            w_pend_nxt  = cfg.cfg_div;
            w_state_nxt = PEND;
          end
        end
        PEND: begin
          w_cnt_nxt = w_cnt_adv;
          if (w_last) begin
            w_cur_nxt   = r_pend_div;
            w_state_nxt = (r_pend_div != '0) ? RUN : IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cur_div  <= '0;
      r_pend_div <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_nxt;
      r_pend_div <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period/position model predicts each cycle's outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic             tick;
    logic             div_out;
    logic             active;
    logic [CNT_W-1:0] cur_div;
    logic             ready;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             tick;
  logic             div_out;
  logic             active;
  logic [CNT_W-1:0] cur_div;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .cfg     (cfg_if.slave),
    .tick    (tick),
    .div_out (div_out),
    .active  (active),
    .cur_div (cur_div)
  );

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_tick_exp = 0;
  int   n_tick_dut = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: whether a period is running, position inside it, ratio, optional pending ratio.
  bit m_run      = 0;
  int m_pos      = 0;
  int m_cur      = 0;
  bit m_has_pend = 0;
  int m_pend     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, predict this cycle's outputs,
  // then advance the model across the next rising edge.
  task automatic step(input logic e, input logic v, input logic [CNT_W-1:0] d, input logic rst_lo);
    exp_t x;
    bit   last;
    bit   acc;
    @(posedge clk);
    #1;
    ena              = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = d;
    rst_n            = !rst_lo;
    if (rst_lo) begin
      m_run = 0; m_pos = 0; m_cur = 0; m_has_pend = 0; m_pend = 0;
    end
    last      = m_run && (m_pos == m_cur - 1);
    x.tick    = last && e;
    x.div_out = m_run && (m_pos < (m_cur + 1) / 2);
    x.active  = m_run;
    x.cur_div = m_run ? CNT_W'(m_cur) : '0;
    x.ready   = e && !m_has_pend;
    if (x.tick) n_tick_exp++;
    exp_q.push_back(x);
    if (e && !rst_lo) begin
      acc = v && x.ready;
      if (!m_run) begin
        if (acc && d != 0) begin
          m_run = 1; m_cur = int'(d); m_pos = 0;
        end
      end else begin
        m_pos = last ? 0 : m_pos + 1;
        if (m_has_pend && last) begin
          m_has_pend = 0;
          if (m_pend == 0) begin
            m_run = 0; m_cur = 0;
          end else begin
            m_cur = m_pend;
          end
        end else if (acc) begin
          m_has_pend = 1; m_pend = int'(d);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("tick",      32'(tick),             32'(mon_e.tick));
        check("div_out",   32'(div_out),          32'(mon_e.div_out));
        check("active",    32'(active),           32'(mon_e.active));
        check("cur_div",   32'(cur_div),          32'(mon_e.cur_div));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(mon_e.ready));
        if (tick === 1'b1) n_tick_dut++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int r;
    logic [CNT_W-1:0] d;
    rst_n            = 1'b0;
    ena              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;

    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 8'd4, 1'b1);

    // N = 4 from IDLE, then 4 -> 3 requested at position 1.
    step(1'b1, 1'b1, 8'd4, 1'b0);
    idle(13);
    for (int i = 0; i < 8 && m_pos != 1; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'd3, 1'b0);
    idle(12);

    // 3 -> 5, then stop request.
    step(1'b1, 1'b1, 8'd5, 1'b0);
    for (int i = 0; i < 10 && m_has_pend; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    idle(8);

    // N = 1 with a three-cycle ena drop (requests refused meanwhile).
    step(1'b1, 1'b1, 8'd1, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd7, 1'b0);
    idle(4);

    // 1 -> 2, then request 6 exactly on a tick cycle of N = 2.
    step(1'b1, 1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 6 && m_has_pend; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4 && m_pos != 1; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 8'd6, 1'b0);
    idle(16);

    // Reset while pending mid-period, then cold-style start with N = 2.
    step(1'b1, 1'b1, 8'd3, 1'b0);
    idle(2);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'd5, 1'b1);
    step(1'b1, 1'b1, 8'd2, 1'b0);
    idle(6);

    // Same-ratio request and the maximum ratio's half-period decode.
    step(1'b1, 1'b1, 8'd2, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 8'd255, 1'b0);
    for (int i = 0; i < 8 && m_has_pend; i++) step(1'b1, 1'b0, '0, 1'b0);
    idle(300);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    idle(260);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 15));
      d = (r == 15) ? CNT_W'($urandom_range(8, 40)) : CNT_W'(r % 6);
      step(($urandom % 8) != 0, ($urandom % 3) == 0, d, ($urandom % 150) == 0);
    end
    idle(4);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("tick_count", 32'(n_tick_dut), 32'(n_tick_exp));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
